// File: rtl/rv_dmem_resp.sv
// Data-memory responder: req/ack handshake, 64-bit word array, WAIT_CYC wait states.
// Optional RV_DMEM_ERR_EN flags out-of-range addresses on err_o instead of wrapping.
module rv_dmem_resp #(
  parameter int DEPTH    = 512,
  parameter int WAIT_CYC = 2,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [63:0] addr_i,
  input  logic [7:0]  strobe_i,
  input  logic [63:0] wdata_i,
  output logic        ack_o,
  output logic [63:0] rdata_o,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t             r_state, w_next;
  logic [3:0]         r_cnt;
  logic               r_we, r_oor;
  logic [IDX_W-1:0]   r_idx;
  logic [7:0]         r_strb;
  logic [63:0]        r_wdata, r_rdata;
  logic [7:0][7:0]    w_rd;

  logic               w_acc, w_enter_ack, w_oor_in;
  logic               w_we, w_oor;
  logic [IDX_W-1:0]   w_idx;
  logic [7:0]         w_strb;
  logic [63:0]        w_wdata;
  logic               w_unused;

  assign w_acc = (r_state == S_IDLE) && req_i;

`ifdef RV_DMEM_ERR_EN
  assign w_oor_in = (addr_i >> (IDX_W + 3)) != 64'd0;
`else
  assign w_oor_in = 1'b0;
`endif
  // upper address bits only matter for range checking; byte offset never does
  assign w_unused = ^{addr_i[2:0], addr_i >> (IDX_W + 3)};

  // with zero wait states the commit happens on the acceptance edge, so bypass the latches
  always_comb begin
    if (r_state == S_IDLE) begin
      w_we    = we_i;
      w_oor   = w_oor_in;
      w_idx   = addr_i[IDX_W+2:3];
      w_strb  = strobe_i;
      w_wdata = wdata_i;
    end else begin
      w_we    = r_we;
      w_oor   = r_oor;
      w_idx   = r_idx;
      w_strb  = r_strb;
      w_wdata = r_wdata;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_i) w_next = (WAIT_CYC == 0) ? S_ACK : S_WAIT;
      S_WAIT: if (r_cnt == 4'd1) w_next = S_ACK;
      S_ACK:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ack_o  = (r_state == S_ACK);
    busy_o = (r_state != S_IDLE);
  end

  assign w_enter_ack = (w_next == S_ACK) && (r_state != S_ACK);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_oor   <= 1'b0;
      r_idx   <= '0;
      r_strb  <= 8'd0;
      r_wdata <= 64'd0;
    end else if (w_acc) begin
      r_cnt   <= 4'(WAIT_CYC);
      r_we    <= we_i;
      r_oor   <= w_oor_in;
      r_idx   <= addr_i[IDX_W+2:3];
      r_strb  <= strobe_i;
      r_wdata <= wdata_i;
    end else if (r_state == S_WAIT) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  // one byte-wide array per lane; contents are never reset
  for (genvar i = 0; i < 8; i++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    always_ff @(posedge clk) begin
      if (rstn && w_enter_ack && w_we && !w_oor && w_strb[i])
        r_mem[w_idx] <= w_wdata[8*i +: 8];
    end
    assign w_rd[i] = r_mem[w_idx];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                    r_rdata <= 64'd0;
    else if (w_enter_ack && w_oor) r_rdata <= 64'd0;
    else if (w_enter_ack && !w_we) r_rdata <= w_rd;
  end
  assign rdata_o = r_rdata;

`ifdef RV_DMEM_ERR_EN
  logic r_err;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_err <= 1'b0;
    else       r_err <= w_enter_ack && w_oor;
  end
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule
